// File: rtl/mips_bus_ram.sv
// Word-organised RAM slave for a MIPS CPU bus with a programmable wait-state
// stall, byte-lane writes, a sticky error flag and a backdoor preload port.
module mips_bus_ram #(
  parameter logic [31:0] BASE_ADDR   = 32'hBFC00000,
  parameter int          DEPTH       = 64,
  parameter int          WAIT_CYCLES = 0,
  localparam int         AW          = $clog2(DEPTH)
) (
  input  logic          clk,
  input  logic          reset,
  input  logic [31:0]   address,
  input  logic          write,
  input  logic          read,
  input  logic [31:0]   writedata,
  input  logic [3:0]    byteenable,
  input  logic          ld_en,
  input  logic [AW-1:0] ld_addr,
  input  logic [31:0]   ld_data,
  output logic          waitrequest,
  output logic [31:0]   readdata,
  output logic          err
);

  localparam logic [32:0] SPAN     = 33'(4 * DEPTH);
  localparam logic [3:0]  CNT_INIT = (WAIT_CYCLES > 0) ? 4'(WAIT_CYCLES - 1) : 4'd0;

  typedef enum logic {IDLE, STALL} state_e;

  state_e      state_q, state_d;
  logic [3:0]  cnt_q, cnt_d;
  logic        wtype_q, wtype_d;
  logic        err_q, err_d;
  logic [31:0] rdata_q, rdata_d;
  logic        wait_c, done;

  logic [31:0] mem [DEPTH];

  logic          req, hit;
  logic [31:0]   off;
  logic [AW-1:0] idx;

  assign req = read ^ write;
  assign off = address - BASE_ADDR;
  // Offset compare is modulo 2^32, so a window near the top of the map still decodes.
  assign hit = ({1'b0, off} < SPAN) && (address[1:0] == 2'b00);
  assign idx = off[AW+1:2];

  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    wtype_d = wtype_q;
    err_d   = err_q;
    rdata_d = rdata_q;
    wait_c  = 1'b0;
    done    = 1'b0;
    if (read && write) begin
      state_d = IDLE;
      err_d   = 1'b1;
    end else begin
      case (state_q)
        IDLE: begin
          if (req) begin
            if (WAIT_CYCLES == 0) begin
              done = 1'b1;
            end else begin
              wait_c  = 1'b1;
              cnt_d   = CNT_INIT;
              wtype_d = write;
              state_d = STALL;
            end
          end
        end
        STALL: begin
          // Master abandoned or switched direction mid-stall: protocol error.
          if (!req || (write != wtype_q)) begin
            state_d = IDLE;
            err_d   = 1'b1;
          end else if (cnt_q != 4'd0) begin
            wait_c = 1'b1;
            cnt_d  = cnt_q - 4'd1;
          end else begin
            done    = 1'b1;
            state_d = IDLE;
          end
        end
        default: state_d = IDLE;
      endcase
    end
    if (done) begin
      if (read) rdata_d = hit ? mem[idx] : 32'h0;
      if (!hit && (address != 32'h0)) err_d = 1'b1;
    end
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q <= IDLE;
      cnt_q   <= 4'd0;
      wtype_q <= 1'b0;
      err_q   <= 1'b0;
      rdata_q <= 32'h0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      wtype_q <= wtype_d;
      err_q   <= err_d;
      rdata_q <= rdata_d;
    end
  end

  // Not reset; backdoor load is applied last so it wins over a same-edge bus write.
  always_ff @(posedge clk) begin
    if (reset && done && write && hit) begin
      for (int b = 0; b < 4; b++) begin
        if (byteenable[b]) mem[idx][8*b +: 8] <= writedata[8*b +: 8];
      end
    end
    if (ld_en) mem[ld_addr] <= ld_data;
  end

  assign waitrequest = reset & wait_c;
  assign readdata    = rdata_q;
  assign err         = err_q;

endmodule
